// File: rtl/ext_pipe.sv
// Pipelined immediate extender: widens an IN_W-bit immediate to OUT_W bits in
// one of five modes, then carries {valid, illegal, data} through STAGES
// registers with stall (hold), flush (clear) and synchronous reset.

// One pipeline register slot: clear beats hold beats load.
module ext_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic         ill_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic         ill_o,
  output logic [W-1:0] data_o
);

  logic         vld_q, ill_q;
  logic [W-1:0] data_q;

  // Slot register: reset/flush zero everything, stall holds, else load.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
      data_q <= '0;
    end else if (en_i) begin
      vld_q  <= vld_i;
      ill_q  <= ill_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign ill_o  = ill_q;
  assign data_o = data_q;

endmodule

module ext_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       ext_op,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] imm_ext,
  output logic             out_illegal
);

  localparam int K = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_d;
  logic             ill_d;

  // Per-stage inputs (_d) and registered contents (_q).
  logic [STAGES-1:0]            vld_d, ill_d_pipe, vld_q, ill_q;
  logic [STAGES-1:0][OUT_W-1:0] data_d, data_q;

  logic adv;
  assign adv = ~stall;

  // Combinational extend feeding stage 0; reserved ops produce 0 and flag illegal.
  always_comb begin
    sext  = {{K{imm[IN_W-1]}}, imm};
    ext_d = '0;
    ill_d = 1'b0;
    case (ext_op)
      3'b000:  ext_d = {{K{1'b0}}, imm};
      3'b001:  ext_d = sext;
      // LUI: imm occupies the top IN_W bits, zeros below (also covers K > IN_W).
      3'b010:  ext_d = {imm, {K{1'b0}}};
      3'b011:  ext_d = {sext[OUT_W-3:0], 2'b00};
      3'b100:  ext_d = {{K{1'b1}}, imm};
      default: ill_d = 1'b1;
    endcase
  end

  assign vld_d[0]      = in_valid;
  assign ill_d_pipe[0] = ill_d;
  assign data_d[0]     = ext_d;

  genvar s;
  generate
    for (s = 1; s < STAGES; s++) begin : g_chain
      assign vld_d[s]      = vld_q[s-1];
      assign ill_d_pipe[s] = ill_q[s-1];
      assign data_d[s]     = data_q[s-1];
    end

    for (s = 0; s < STAGES; s++) begin : g_stage
      ext_stage #(.W(OUT_W)) u_stage (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (flush),
        .en_i   (adv),
        .vld_i  (vld_d[s]),
        .ill_i  (ill_d_pipe[s]),
        .data_i (data_d[s]),
        .vld_o  (vld_q[s]),
        .ill_o  (ill_q[s]),
        .data_o (data_q[s])
      );
    end
  endgenerate

  assign out_valid   = vld_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];
  assign imm_ext     = data_q[STAGES-1];

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: three instances (STAGES=1, STAGES=3, and an 8->16 bit
// STAGES=2 sweep) checked against an arithmetic reference of the extend modes
// and an "output equals the entry from STAGES advances ago" pipeline model.
module tb_ext_pipe;

  typedef struct {
    logic        v;
    logic        il;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // STAGES=1 instance
  logic        r1, v1, st1, fl1, ov1, oi1;
  logic [15:0] i1;
  logic [2:0]  o1;
  logic [31:0] e1;
  // STAGES=3 instance
  logic        r3, v3, st3, fl3, ov3, oi3;
  logic [15:0] i3;
  logic [2:0]  o3;
  logic [31:0] e3;
  // IN_W=8, OUT_W=16, STAGES=2 instance
  logic        r8, v8, st8, fl8, ov8, oi8;
  logic [7:0]  i8;
  logic [2:0]  o8;
  logic [15:0] e8;

  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) u1 (
    .clk(clk), .reset(r1), .in_valid(v1), .imm(i1), .ext_op(o1), .stall(st1),
    .flush(fl1), .out_valid(ov1), .imm_ext(e1), .out_illegal(oi1));
  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3)) u3 (
    .clk(clk), .reset(r3), .in_valid(v3), .imm(i3), .ext_op(o3), .stall(st3),
    .flush(fl3), .out_valid(ov3), .imm_ext(e3), .out_illegal(oi3));
  ext_pipe #(.IN_W(8), .OUT_W(16), .STAGES(2)) u8 (
    .clk(clk), .reset(r8), .in_valid(v8), .imm(i8), .ext_op(o8), .stall(st8),
    .flush(fl8), .out_valid(ov8), .imm_ext(e8), .out_illegal(oi8));

  // Reference extend computed with plain modular arithmetic.
  function automatic logic [31:0] ref_ext(int iw, int ow, longint unsigned im, int op);
    longint unsigned md = 64'd1 << ow;
    longint unsigned sv;
    sv = (im >= (64'd1 << (iw - 1))) ? im + md - (64'd1 << iw) : im;
    case (op)
      0:       return 32'(im);
      1:       return 32'(sv);
      2:       return 32'((im << (ow - iw)) % md);
      3:       return 32'((sv * 4) % md);
      4:       return 32'(md - (64'd1 << iw) + im);
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    r1 = 1; v1 = 0; i1 = 0; o1 = 0; st1 = 0; fl1 = 0;
    r3 = 1; v3 = 0; i3 = 0; o3 = 0; st3 = 0; fl3 = 0;
    r8 = 1; v8 = 0; i8 = 0; o8 = 0; st8 = 0; fl8 = 0;
    tick; tick; tick;
    nvec += 3;
    if ({ov1, oi1} !== 2'b00 || e1 !== 32'd0) begin nerr++; $display("FAIL reset_u1 got v=%b il=%b d=%h want 0 0 0", ov1, oi1, e1); end
    if ({ov3, oi3} !== 2'b00 || e3 !== 32'd0) begin nerr++; $display("FAIL reset_u3 got v=%b il=%b d=%h want 0 0 0", ov3, oi3, e3); end
    if ({ov8, oi8} !== 2'b00 || e8 !== 16'd0) begin nerr++; $display("FAIL reset_u8 got v=%b il=%b d=%h want 0 0 0", ov8, oi8, e8); end
    r1 = 0; r3 = 0; r8 = 0;
  endtask

  task automatic test_sign_zero;
    v1 = 1; i1 = 16'h8001; o1 = 3'b001;
    tick;
    nvec++;
    if (e1 !== 32'hFFFF8001 || ov1 !== 1'b1) begin nerr++; $display("FAIL t1_sign got %h v=%b want ffff8001 v=1", e1, ov1); end
    o1 = 3'b000;
    tick;
    nvec++;
    if (e1 !== 32'h00008001 || ov1 !== 1'b1) begin nerr++; $display("FAIL t1_zero got %h v=%b want 00008001 v=1", e1, ov1); end
    v1 = 0;
  endtask

  task automatic test_modes;
    logic [15:0] ti [4] = '{16'h1234, 16'hFFFF, 16'h00F0, 16'h5555};
    logic [2:0]  to [4] = '{3'b010, 3'b011, 3'b100, 3'b110};
    logic [31:0] te [4] = '{32'h12340000, 32'hFFFFFFFC, 32'hFFFF00F0, 32'h0};
    logic        tl [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      v1 = 1; i1 = ti[k]; o1 = to[k];
      tick;
      nvec++;
      if (e1 !== te[k] || oi1 !== tl[k] || ov1 !== 1'b1)
        begin nerr++; $display("FAIL mode%0d got d=%h il=%b v=%b want d=%h il=%b v=1", k, e1, oi1, ov1, te[k], tl[k]); end
    end
    v1 = 0;
  endtask

  task automatic test_random_s1;
    logic [31:0] ex;
    for (int k = 0; k < 200; k++) begin
      v1 = 1'($urandom_range(0, 1));
      i1 = 16'($urandom);
      o1 = 3'($urandom_range(0, 7));
      ex = ref_ext(16, 32, longint'(i1), int'(o1));
      tick;
      nvec++;
      if (ov1 !== v1 || oi1 !== (o1 > 3'd4) || e1 !== ex)
        begin nerr++; $display("FAIL rand_s1 imm=%h op=%0d got v=%b il=%b d=%h want v=%b il=%b d=%h", i1, o1, ov1, oi1, e1, v1, o1 > 3'd4, ex); end
    end
    v1 = 0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] val [3];
    logic [31:0] got [3];
    int          at  [3];
    int          n = 0;
    for (int k = 0; k < 3; k++) val[k] = 16'($urandom);
    o3 = 3'b001;
    for (int e = 0; e < 10; e++) begin
      st3 = (e == 2 || e == 3);
      v3  = (e <= 4);
      i3  = (e == 0) ? val[0] : (e == 1) ? val[1] : val[2];
      tick;
      if (ov3 === 1'b1) begin
        if (n < 3) begin got[n] = e3; at[n] = e; end
        n++;
      end
    end
    st3 = 0; v3 = 0;
    nvec++;
    if (n !== 3) begin nerr++; $display("FAIL b2b_count got %0d want 3", n); end
    else begin
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (got[k] !== ref_ext(16, 32, longint'(val[k]), 1) || at[k] !== 4 + k)
          begin nerr++; $display("FAIL b2b_entry%0d got d=%h edge=%0d want d=%h edge=%0d", k, got[k], at[k], ref_ext(16, 32, longint'(val[k]), 1), 4 + k); end
      end
    end
  endtask

  task automatic test_flush;
    logic [15:0] dv;
    o3 = 3'b000;
    for (int k = 0; k < 3; k++) begin v3 = 1; i3 = 16'($urandom | 1); tick; end
    st3 = 1; fl3 = 1; i3 = 16'hBEEF;
    tick;
    st3 = 0; fl3 = 0;
    nvec++;
    if (ov3 !== 1'b0 || e3 !== 32'd0 || oi3 !== 1'b0) begin nerr++; $display("FAIL flush_out got v=%b d=%h il=%b want 0 0 0", ov3, e3, oi3); end
    v3 = 0; i3 = 16'h0;
    for (int k = 0; k < 2; k++) begin
      tick;
      nvec++;
      if (ov3 !== 1'b0 || e3 !== 32'd0) begin nerr++; $display("FAIL flush_drain%0d got v=%b d=%h want 0 0", k, ov3, e3); end
    end
    dv = 16'($urandom | 16'h0100);
    v3 = 1; i3 = dv; o3 = 3'b000;
    tick;
    v3 = 0;
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (ov3 !== 1'b0) begin nerr++; $display("FAIL flush_early%0d got v=%b want 0", k, ov3); end
      tick;
    end
    nvec++;
    if (ov3 !== 1'b1 || e3 !== {16'h0, dv}) begin nerr++; $display("FAIL flush_next got v=%b d=%h want 1 %h", ov3, e3, {16'h0, dv}); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] nv;
    o3 = 3'b100;
    for (int k = 0; k < 4; k++) begin v3 = 1; i3 = 16'($urandom); tick; end
    r3 = 1;
    tick;
    r3 = 0;
    nvec++;
    if (ov3 !== 1'b0 || e3 !== 32'd0 || oi3 !== 1'b0) begin nerr++; $display("FAIL reset_mid got v=%b d=%h il=%b want 0 0 0", ov3, e3, oi3); end
    nv = 16'($urandom);
    v3 = 1; i3 = nv; o3 = 3'b010;
    tick;
    v3 = 0;
    tick;
    nvec++;
    if (ov3 !== 1'b0) begin nerr++; $display("FAIL reset_mid_early got v=%b want 0", ov3); end
    tick;
    nvec++;
    if (ov3 !== 1'b1 || e3 !== {nv, 16'h0}) begin nerr++; $display("FAIL reset_mid_first got v=%b d=%h want 1 %h", ov3, e3, {nv, 16'h0}); end
  endtask

  task automatic test_random_s3;
    ent_t q[$];
    ent_t ex;
    ent_t ne;
    for (int k = 0; k < 400; k++) begin
      r3  = (k == 0) || ($urandom_range(0, 31) == 0);
      fl3 = ($urandom_range(0, 15) == 0);
      st3 = ($urandom_range(0, 3) == 0);
      v3  = 1'($urandom_range(0, 1));
      i3  = 16'($urandom);
      o3  = 3'($urandom_range(0, 7));
      ne.v = v3; ne.il = (o3 > 3'd4); ne.d = ref_ext(16, 32, longint'(i3), int'(o3));
      tick;
      if (r3 || fl3) q.delete();
      else if (!st3) begin
        q.push_back(ne);
        if (q.size() > 3) void'(q.pop_front());
      end
      if (q.size() == 3) ex = q[0];
      else begin ex.v = 0; ex.il = 0; ex.d = 0; end
      nvec++;
      if (ov3 !== ex.v || oi3 !== ex.il || e3 !== ex.d)
        begin nerr++; $display("FAIL rand_s3 iter %0d got v=%b il=%b d=%h want v=%b il=%b d=%h", k, ov3, oi3, e3, ex.v, ex.il, ex.d); end
    end
    r3 = 0; fl3 = 0; st3 = 0; v3 = 0;
  endtask

  task automatic test_sweep;
    logic [15:0] h [$];
    logic        hv [$];
    v8 = 1; i8 = 8'h80; o8 = 3'b001;
    tick;
    v8 = 0;
    tick;
    nvec++;
    if (e8 !== 16'hFF80 || ov8 !== 1'b1) begin nerr++; $display("FAIL sweep_sign got %h v=%b want ff80 v=1", e8, ov8); end
    for (int k = 0; k < 150; k++) begin
      v8 = 1'($urandom_range(0, 1));
      i8 = 8'($urandom);
      o8 = 3'($urandom_range(0, 4));
      h.push_back(16'(ref_ext(8, 16, longint'(i8), int'(o8))));
      hv.push_back(v8);
      tick;
      if (h.size() == 2) begin
        nvec++;
        if (e8 !== h[0] || ov8 !== hv[0]) begin nerr++; $display("FAIL sweep_rand iter %0d got d=%h v=%b want d=%h v=%b", k, e8, ov8, h[0], hv[0]); end
        void'(h.pop_front());
        void'(hv.pop_front());
      end
    end
    v8 = 0;
  endtask

  initial begin
    test_reset;
    test_sign_zero;
    test_modes;
    test_random_s1;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_random_s3;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
